rd_fram_buf: RTL and testbench
==============================

RD_FRAM_BUF -- requirements
Module: rd_fram_buf

Interface
REQ-001 The block SHALL expose parameter DATA_WIDTH, default 128, word width of both ports.
REQ-002 The block SHALL expose parameter ADDR_WIDTH, default 10, address width; depth is 2**ADDR_WIDTH (1024 words).
REQ-003 The block SHALL use one clock, and its reset SHALL be asynchronous and active-low.
REQ-004 clk  input  1  the single clock; all port A and port B activity is sampled on its rising edge.
REQ-005 rstn  input  1  asynchronous active-low reset.
REQ-006 a_addr  input  ADDR_WIDTH  port A word address.
REQ-007 a_wr_data  input  DATA_WIDTH  port A write data.
REQ-008 a_wr_en  input  1  port A write enable.
REQ-009 a_rd_data  output  DATA_WIDTH  port A registered read data.
REQ-010 b_addr  input  ADDR_WIDTH  port B word address.
REQ-011 b_wr_data  input  DATA_WIDTH  port B write data.
REQ-012 b_wr_en  input  1  port B write enable.
REQ-013 b_rd_data  output  DATA_WIDTH  port B registered read data.

Function
REQ-014 The block SHALL be a true dual-port RAM of 2**ADDR_WIDTH words of DATA_WIDTH bits, and both ports SHALL be fully independent read/write ports.
REQ-015 A write SHALL occur on the rising clk edge when the port's wr_en=1: mem[addr] <= wr_data.
REQ-016 Every port SHALL read every cycle regardless of wr_en: x_rd_data <= mem[x_addr] on each rising edge, giving one-cycle read latency from address to data.
REQ-017 Same-port read-during-write SHALL be read-first: x_rd_data returns the pre-write contents of the address.
REQ-018 A cross-port read of an address written in the same cycle by the other port SHALL return the old (pre-write) contents; the new value SHALL be visible on the next read.
REQ-019 Simultaneous writes by both ports to the same address SHALL resolve with port B winning, and the stored word SHALL equal b_wr_data.
REQ-020 Addresses SHALL be taken modulo depth with no out-of-range state; addresses 0 and 2**ADDR_WIDTH-1 SHALL be usable like any other.
REQ-021 rd_data SHALL hold its last value while the address is static and no write targets that address.

Reset
REQ-022 rstn=0 SHALL asynchronously clear a_rd_data and b_rd_data to 0.
REQ-023 Memory contents SHALL NOT be cleared by reset, so that RAM inference is preserved; the contents after power-up are undefined.
REQ-024 While rstn=0, writes SHALL be ignored and rd_data SHALL stay 0; normal operation SHALL resume on the first rising clk edge after rstn deasserts.
REQ-025 An assertion of rstn during a write SHALL abort only the output registers; any edge already taken before assertion SHALL remain written.

Structure
REQ-026 The shared package SHALL hold the default DATA_WIDTH (128) and ADDR_WIDTH (10) constants and the derived DEPTH constant.
REQ-027 The block SHALL be a single module with no sub-module; the memory array SHALL be coded in a form the synthesis tool infers as block RAM.
REQ-028 Consumers that need independent clocks SHALL NOT use this block; it is single-clock only.

Verification
REQ-029 Reset test: assert rstn=0 mid-run -> a_rd_data and b_rd_data read 0 immediately, without waiting for a clk edge.
REQ-030 Basic write/read test: write 0x0123..EF (128 bit) via port A at address 5; read port B address 5 next cycle -> the value appears on b_rd_data exactly 1 cycle after the address is presented.
REQ-031 Sequential fill test: write addresses 0..1023 with data=address via port A; read them back via port B with an incrementing address -> b_rd_data equals address-1 each cycle, including the wrap from address 1023 to 0.
REQ-032 Read-first test: address 7 holds 0xAA; port A writes 0xBB to address 7 while ports A and B both read address 7 -> both return 0xAA that cycle and 0xBB the next cycle.
REQ-033 Write-collision test: both ports write address 9 in the same cycle (A=0x11, B=0x22) -> a later read returns 0x22.
REQ-034 Concurrent-streams test: port A writes while port B reads different addresses at random -> the checker model matches rd_data on every cycle.

Source files
------------

// File: rtl/rd_fram_buf_pkg.sv
// rd_fram_buf_pkg
//   Shared constants for the frame read buffer: default word width, default
//   address width and the derived word depth.
package rd_fram_buf_pkg;

    localparam int unsigned RD_FRAM_DATA_WIDTH = 128;
    localparam int unsigned RD_FRAM_ADDR_WIDTH = 10;
    localparam int unsigned RD_FRAM_DEPTH      = 1 << RD_FRAM_ADDR_WIDTH;

endpackage

// File: rtl/rd_fram_buf.sv
// rd_fram_buf
//   Single-clock true dual-port RAM used as the frame read buffer.
//   Both ports read every cycle with one-cycle latency and may write
//   independently.
//
//   Behaviour:
//     - Same-port and cross-port read-during-write are read-first.
//     - Same-address writes from both ports in one cycle leave port B's data.
//     - Reset clears only the read registers. Memory contents are kept.
//     - Writes are ignored while reset is held.
//
//   Ports:
//     clk        single clock, rising-edge active
//     rstn       asynchronous active-low reset
//     a_addr     port A word address
//     a_wr_data  port A write data
//     a_wr_en    port A write enable
//     a_rd_data  port A registered read data
//     b_addr     port B word address
//     b_wr_data  port B write data
//     b_wr_en    port B write enable
//     b_rd_data  port B registered read data
module rd_fram_buf
    import rd_fram_buf_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = RD_FRAM_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = RD_FRAM_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wr_data,
    input  logic                  a_wr_en,
    output logic [DATA_WIDTH-1:0] a_rd_data,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wr_data,
    input  logic                  b_wr_en,
    output logic [DATA_WIDTH-1:0] b_rd_data
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    // The address width spans the whole array, so every address is in range.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic a_wr_q;
    logic b_wr_q;

    // Writes are gated by rstn so nothing lands while the block is in reset.
    always_comb begin
        a_wr_q = a_wr_en & rstn;
        b_wr_q = b_wr_en & rstn;
    end

    // Memory has no reset, so the array can map onto block RAM.
    // Port B is written last, so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (a_wr_q) begin
            mem[a_addr] <= a_wr_data;
        end
        if (b_wr_q) begin
            mem[b_addr] <= b_wr_data;
        end
    end

    // The read registers sample the pre-edge contents of the array.
    // Because of that, any write in the same cycle is seen one read later.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            a_rd_data <= '0;
            b_rd_data <= '0;
        end else begin
            a_rd_data <= mem[a_addr];
            b_rd_data <= mem[b_addr];
        end
    end

endmodule

// File: tb/tb_rd_fram_buf.sv
// tb_rd_fram_buf
//   Directed self-checking bench for rd_fram_buf. A reference array tracks
//   the expected memory contents. Read data is sampled 1 ns after each
//   rising edge.
module tb_rd_fram_buf;

    localparam int unsigned DW    = 128;
    localparam int unsigned AW    = 10;
    localparam int unsigned DEPTH = 1 << AW;

    logic          clk;
    logic          rstn;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wr_data;
    logic          a_wr_en;
    logic [DW-1:0] a_rd_data;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wr_data;
    logic          b_wr_en;
    logic [DW-1:0] b_rd_data;

    logic [DW-1:0] model [DEPTH];

    int n_total;
    int n_bad;

    rd_fram_buf #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .a_addr    (a_addr),
        .a_wr_data (a_wr_data),
        .a_wr_en   (a_wr_en),
        .a_rd_data (a_rd_data),
        .b_addr    (b_addr),
        .b_wr_data (b_wr_data),
        .b_wr_en   (b_wr_en),
        .b_rd_data (b_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [DW-1:0] exp_a;
    logic [DW-1:0] exp_b;
    logic [DW-1:0] hold_v;
    logic [DW-1:0] pat;

    initial begin
        n_total   = 0;
        n_bad     = 0;
        rstn      = 1'b0;
        a_addr    = '0;
        b_addr    = '0;
        a_wr_data = '0;
        b_wr_data = '0;
        a_wr_en   = 1'b0;
        b_wr_en   = 1'b0;

        // Reset state.
        tick();
        tick();
        chk("rst_a", a_rd_data, '0);
        chk("rst_b", b_rd_data, '0);
        rstn = 1'b1;
        tick();

        // Basic write and read: port A writes address 5, then port B reads it.
        pat       = 128'h0123456789abcdef_0123456789abcdef;
        a_addr    = 10'd5;
        a_wr_data = pat;
        a_wr_en   = 1'b1;
        b_addr    = 10'd6;
        tick();
        a_wr_en   = 1'b0;
        model[5]  = pat;
        b_addr    = 10'd5;
        tick();
        chk("basic_b", b_rd_data, pat);

        // Sequential fill through port A with data equal to the address.
        for (int i = 0; i < int'(DEPTH); i++) begin
            a_addr    = AW'(i);
            a_wr_data = DW'(i);
            a_wr_en   = 1'b1;
            tick();
            model[i] = DW'(i);
        end
        a_wr_en = 1'b0;

        // Readback through port B, including the wrap from 1023 to 0.
        for (int i = 0; i < int'(DEPTH) + 2; i++) begin
            b_addr = AW'(i % int'(DEPTH));
            tick();
            chk($sformatf("fill_%0d", i % int'(DEPTH)), b_rd_data, DW'(i % int'(DEPTH)));
        end

        // Read-first on the same port and across ports.
        a_addr    = 10'd7;
        a_wr_data = 128'haa;
        a_wr_en   = 1'b1;
        tick();
        model[7]  = 128'haa;
        a_wr_data = 128'hbb;
        b_addr    = 10'd7;
        tick();
        chk("rf_a_old", a_rd_data, 128'haa);
        chk("rf_b_old", b_rd_data, 128'haa);
        a_wr_en = 1'b0;
        model[7] = 128'hbb;
        tick();
        chk("rf_a_new", a_rd_data, 128'hbb);
        chk("rf_b_new", b_rd_data, 128'hbb);

        // Cross-port read-first with port B writing while port A reads.
        a_addr    = 10'd12;
        b_addr    = 10'd12;
        b_wr_data = 128'hc0ffee;
        b_wr_en   = 1'b1;
        tick();
        chk("xb_a_old", a_rd_data, 128'd12);
        b_wr_en   = 1'b0;
        model[12] = 128'hc0ffee;
        tick();
        chk("xb_a_new", a_rd_data, 128'hc0ffee);

        // Write collision: port B must win.
        a_addr    = 10'd9;
        b_addr    = 10'd9;
        a_wr_data = 128'h11;
        b_wr_data = 128'h22;
        a_wr_en   = 1'b1;
        b_wr_en   = 1'b1;
        tick();
        a_wr_en  = 1'b0;
        b_wr_en  = 1'b0;
        model[9] = 128'h22;
        tick();
        chk("coll_a", a_rd_data, 128'h22);
        chk("coll_b", b_rd_data, 128'h22);

        // Hold with a static address and no writes.
        a_addr = 10'd1023;
        b_addr = 10'd0;
        tick();
        tick();
        tick();
        chk("hold_a", a_rd_data, 128'd1023);
        chk("hold_b", b_rd_data, 128'd0);

        // Concurrent streams with random addresses, data and enables.
        for (int i = 0; i < 300; i++) begin
            a_addr    = AW'($urandom_range(DEPTH - 1));
            b_addr    = AW'($urandom_range(DEPTH - 1));
            if (i % 7 == 0) b_addr = a_addr;
            a_wr_data = {$urandom, $urandom, $urandom, $urandom};
            b_wr_data = {$urandom, $urandom, $urandom, $urandom};
            a_wr_en   = 1'($urandom_range(1));
            b_wr_en   = ($urandom_range(3) == 0);
            exp_a     = model[a_addr];
            exp_b     = model[b_addr];
            tick();
            if (a_wr_en) model[a_addr] = a_wr_data;
            if (b_wr_en) model[b_addr] = b_wr_data;
            chk($sformatf("rnd_a_%0d", i), a_rd_data, exp_a);
            chk($sformatf("rnd_b_%0d", i), b_rd_data, exp_b);
        end
        a_wr_en = 1'b0;
        b_wr_en = 1'b0;

        // Mid-run reset: outputs clear without a clock edge, and writes are ignored.
        a_addr = 10'd7;
        b_addr = 10'd7;
        tick();
        hold_v = model[7];
        chk("pre_rst_b", b_rd_data, hold_v);
        #2;
        rstn = 1'b0;
        #1;
        chk("async_rst_a", a_rd_data, '0);
        chk("async_rst_b", b_rd_data, '0);
        a_addr    = 10'd20;
        a_wr_data = 128'hdead;
        a_wr_en   = 1'b1;
        tick();
        tick();
        chk("in_rst_a", a_rd_data, '0);
        chk("in_rst_b", b_rd_data, '0);
        a_wr_en = 1'b0;
        rstn    = 1'b1;
        b_addr  = 10'd20;
        tick();
        chk("post_rst_a", a_rd_data, model[20]);
        chk("post_rst_b", b_rd_data, model[20]);
        a_addr = 10'd5;
        tick();
        chk("mem_kept", a_rd_data, model[5]);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
